// File: rtl/sort_pkg.sv
// Shared definitions for the sort job sequencer: parameter defaults and FSM encoding.
package sort_pkg;
  localparam int MAX_NUM_VALUES_DEF = 1024;
  localparam int DATA_ADDR_BITS_DEF = 10;
  localparam int DATA_WIDTH_DEF     = 64;

  typedef enum logic [1:0] {IDLE, LOAD, SORT, DRAIN} state_t;
endpackage

// File: rtl/sort_out_skid.sv
// Two-entry output buffer for the drain path; the producer guarantees it never overfills.
module sort_out_skid #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem [2];
  logic             wptr, rptr, pop;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (in_valid) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (in_valid) wptr <= ~wptr;
      if (pop)      rptr <= ~rptr;
      count <= count + 2'(in_valid) - 2'(pop);
    end
  end
endmodule

// File: rtl/sort_job_sequencer.sv
// Runs one sort job: load N words into RAM, hand the RAM to an external sorter, then stream results out.
module sort_job_sequencer
  import sort_pkg::*;
#(
  parameter int MAX_NUM_VALUES = MAX_NUM_VALUES_DEF,
  parameter int DATA_ADDR_BITS = DATA_ADDR_BITS_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_start,
  input  logic [DATA_ADDR_BITS:0]   job_num_values,
  output logic                      job_busy,
  output logic                      job_done,
  output logic                      job_error,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_last,
  output logic                      sorter_start,
  output logic [DATA_ADDR_BITS:0]   sorter_num_values,
  input  logic                      sorter_done,
  input  logic                      s_we_a,
  input  logic [DATA_ADDR_BITS-1:0] s_w_addr_a,
  input  logic [DATA_ADDR_BITS-1:0] s_r_addr_a,
  input  logic [DATA_WIDTH-1:0]     s_w_data_a,
  output logic [DATA_WIDTH-1:0]     s_r_data_a,
  input  logic                      s_we_b,
  input  logic [DATA_ADDR_BITS-1:0] s_w_addr_b,
  input  logic [DATA_ADDR_BITS-1:0] s_r_addr_b,
  input  logic [DATA_WIDTH-1:0]     s_w_data_b,
  output logic [DATA_WIDTH-1:0]     s_r_data_b,
  output logic                      ram_we_a,
  output logic [DATA_ADDR_BITS-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0]     ram_w_data_a,
  input  logic [DATA_WIDTH-1:0]     ram_r_data_a,
  output logic                      ram_we_b,
  output logic [DATA_ADDR_BITS-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0]     ram_w_data_b,
  input  logic [DATA_WIDTH-1:0]     ram_r_data_b
);
  localparam int CW = DATA_ADDR_BITS + 1;

  state_t        state;
  logic [CW-1:0] n_reg, idx, out_cnt;
  logic          rd_inflight, pop, issue, last_load;
  logic [1:0]    buf_cnt;
  logic [2:0]    occ;

  assign sorter_num_values = n_reg;
  assign in_ready          = (state == LOAD);
  assign s_r_data_a        = ram_r_data_a;
  assign s_r_data_b        = ram_r_data_b;

  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (out_cnt == n_reg - CW'(1));
  assign last_load = in_valid && (idx == n_reg - CW'(1));

  // An item leaving this cycle frees a slot, which keeps one read per cycle in flight.
  assign occ   = 3'(buf_cnt) + 3'(rd_inflight);
  assign issue = (state == DRAIN) && (idx < n_reg) && (occ < 3'd2 + 3'(pop));

  always_comb begin
    ram_we_a     = 1'b0;
    ram_addr_a   = '0;
    ram_w_data_a = '0;
    ram_we_b     = 1'b0;
    ram_addr_b   = '0;
    ram_w_data_b = '0;
    unique case (state)
      LOAD: begin
        ram_we_a     = in_valid;
        ram_addr_a   = idx[DATA_ADDR_BITS-1:0];
        ram_w_data_a = in_data;
      end
      SORT: begin
        ram_we_a     = s_we_a;
        ram_addr_a   = s_we_a ? s_w_addr_a : s_r_addr_a;
        ram_w_data_a = s_w_data_a;
        ram_we_b     = s_we_b;
        ram_addr_b   = s_we_b ? s_w_addr_b : s_r_addr_b;
        ram_w_data_b = s_w_data_b;
      end
      DRAIN:   ram_addr_a = idx[DATA_ADDR_BITS-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      n_reg        <= '0;
      idx          <= '0;
      out_cnt      <= '0;
      rd_inflight  <= 1'b0;
      job_busy     <= 1'b0;
      job_done     <= 1'b0;
      job_error    <= 1'b0;
      sorter_start <= 1'b0;
    end else begin
      job_done     <= 1'b0;
      job_error    <= 1'b0;
      sorter_start <= 1'b0;
      unique case (state)
        IDLE: if (job_start) begin
          if (job_num_values != '0 && job_num_values <= CW'(MAX_NUM_VALUES)) begin
            n_reg    <= job_num_values;
            idx      <= '0;
            out_cnt  <= '0;
            job_busy <= 1'b1;
            state    <= LOAD;
          end else begin
            job_error <= 1'b1;
          end
        end
        LOAD: if (in_valid) begin
          idx <= idx + CW'(1);
          if (last_load) begin
            idx <= '0;
            // A single item is already sorted; skip the sorter entirely.
            if (n_reg == CW'(1)) state <= DRAIN;
            else begin
              state        <= SORT;
              sorter_start <= 1'b1;
            end
          end
        end
        SORT: if (sorter_done) begin
          state <= DRAIN;
          idx   <= '0;
        end
        DRAIN: begin
          rd_inflight <= issue;
          if (issue) idx <= idx + CW'(1);
          if (pop) begin
            out_cnt <= out_cnt + CW'(1);
            if (out_last) begin
              state    <= IDLE;
              job_busy <= 1'b0;
              job_done <= 1'b1;
              out_cnt  <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sort_out_skid #(.WIDTH(DATA_WIDTH)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_inflight),
    .in_data  (ram_r_data_a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (buf_cnt)
  );
endmodule

// File: tb/tb_sort_job_sequencer.sv
// Bench for sort_job_sequencer: RAM and sorter models around the DUT, outputs scored against a sorted copy of the input.
module tb_sort_job_sequencer;
  localparam int AW = 10;
  localparam int DW = 64;

  logic          clk, rst;
  logic          job_start, job_busy, job_done, job_error;
  logic [AW:0]   job_num_values, sorter_num_values;
  logic          in_valid, in_ready, out_valid, out_ready, out_last;
  logic [DW-1:0] in_data, out_data;
  logic          sorter_start, sorter_done;
  logic          s_we_a, s_we_b, ram_we_a, ram_we_b;
  logic [AW-1:0] s_w_addr_a, s_r_addr_a, s_w_addr_b, s_r_addr_b, ram_addr_a, ram_addr_b;
  logic [DW-1:0] s_w_data_a, s_r_data_a, s_w_data_b, s_r_data_b;
  logic [DW-1:0] ram_w_data_a, ram_r_data_a, ram_w_data_b, ram_r_data_b;

  sort_job_sequencer dut (
    .clk(clk), .rst(rst),
    .job_start(job_start), .job_num_values(job_num_values),
    .job_busy(job_busy), .job_done(job_done), .job_error(job_error),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sorter_start(sorter_start), .sorter_num_values(sorter_num_values), .sorter_done(sorter_done),
    .s_we_a(s_we_a), .s_w_addr_a(s_w_addr_a), .s_r_addr_a(s_r_addr_a),
    .s_w_data_a(s_w_data_a), .s_r_data_a(s_r_data_a),
    .s_we_b(s_we_b), .s_w_addr_b(s_w_addr_b), .s_r_addr_b(s_r_addr_b),
    .s_w_data_b(s_w_data_b), .s_r_data_b(s_r_data_b),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_w_data_a(ram_w_data_a), .ram_r_data_a(ram_r_data_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_w_data_b(ram_w_data_b), .ram_r_data_b(ram_r_data_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Dual-port RAM with one-cycle read latency.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_w_data_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_w_data_b;
    ram_r_data_a <= mem[ram_addr_a];
    ram_r_data_b <= mem[ram_addr_b];
  end

  int compared = 0, mismatched = 0;
  int got_cnt, done_cnt, start_cnt = 0, wr_cnt = 0, exp_n, stall_pct = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sorter_idle();
    s_we_a = 0; s_we_b = 0; sorter_done = 0;
    s_w_addr_a = '0; s_r_addr_a = '0; s_w_data_a = '0;
    s_w_addr_b = '0; s_r_addr_b = '0; s_w_data_b = '0;
  endtask

  // Sorter model: reads all words through both ports, sorts them, writes them back, then signals done.
  task automatic run_sorter();
    int n;
    logic [DW-1:0] v[$];
    n = int'(sorter_num_values);
    for (int i = 0; i < n; i += 2) begin
      s_r_addr_a = AW'(i);
      s_r_addr_b = AW'((i + 1 < n) ? i + 1 : i);
      @(negedge clk);
      if (rst) begin sorter_idle(); return; end
      v.push_back(s_r_data_a);
      if (i + 1 < n) v.push_back(s_r_data_b);
    end
    v.sort();
    s_r_addr_a = AW'(1023); s_r_addr_b = AW'(1022);
    for (int i = 0; i < n; i += 2) begin
      s_we_a = 1; s_w_addr_a = AW'(i); s_w_data_a = v[i];
      s_we_b = (i + 1 < n);
      s_w_addr_b = AW'(i + 1); s_w_data_b = (i + 1 < n) ? v[i+1] : '0;
      @(negedge clk);
      if (rst) begin sorter_idle(); return; end
    end
    sorter_idle();
    sorter_done = 1;
    @(negedge clk);
    sorter_done = 0;
  endtask

  initial begin
    sorter_idle();
    forever begin
      @(negedge clk);
      if (sorter_start && !rst) run_sorter();
    end
  end

  initial begin
    out_ready = 1;
    forever begin
      tick();
      out_ready = ($urandom_range(99) >= stall_pct);
    end
  end

  // Output monitor: scoreboard, stall stability and event counters.
  initial begin
    logic stalled_prev, prev_last;
    logic [DW-1:0] prev_data, e;
    stalled_prev = 0; prev_last = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin stalled_prev = 0; continue; end
      if (stalled_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_output", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
          chk("out_last", out_last, (got_cnt == exp_n - 1));
        end
        got_cnt++;
      end
      stalled_prev = out_valid && !out_ready;
      prev_data = out_data; prev_last = out_last;
      if (job_done) done_cnt++;
      if (sorter_start) start_cnt++;
      if (ram_we_a || ram_we_b) wr_cnt++;
    end
  end

  task automatic run_job(input int n, input int stall, input bit exp_err, input int exp_starts,
                         input bit use_dead, input bit poke, input bit rst_sort);
    logic [DW-1:0] d[$];
    int i, guard, wr0, st0;
    bit hs;
    wr0 = wr_cnt; st0 = start_cnt;
    for (int k = 0; k < n && !exp_err; k++) d.push_back(use_dead ? 64'hDEAD : {$urandom, $urandom});
    exp_q = d; exp_q.sort(); exp_n = n; got_cnt = 0; done_cnt = 0; stall_pct = stall;
    job_num_values = (AW+1)'(n); job_start = 1; in_valid = exp_err;
    tick();
    job_start = 0;
    if (exp_err) begin
      chk("job_error", job_error, 1);
      chk("err_busy", job_busy, 0);
      chk("err_in_ready", in_ready, 0);
      tick();
      in_valid = 0;
      chk("job_error_pulse", job_error, 0);
      chk("err_no_write", wr_cnt - wr0, 0);
      return;
    end
    chk("busy", job_busy, 1);
    chk("num_values", sorter_num_values, n);
    i = 0; guard = 0;
    while (i < n && guard < 4000) begin
      in_valid = ($urandom_range(3) != 0); in_data = d[i];
      if (poke && i == n / 2) begin job_start = 1; job_num_values = 11'd5; end
      hs = in_valid && in_ready;
      tick();
      job_start = 0; guard++;
      if (hs) i++;
    end
    in_valid = 0;
    if (i < n) chk("load_timeout", i, n);
    if (rst_sort) begin
      guard = 0;
      while (start_cnt == st0 && guard < 100) begin tick(); guard++; end
      chk("sort_started", start_cnt - st0, 1);
      tick(); tick();
      rst = 1;
      tick();
      chk("rst_busy", job_busy, 0);     chk("rst_done", job_done, 0);
      chk("rst_error", job_error, 0);   chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0); chk("rst_out_last", out_last, 0);
      chk("rst_sorter_start", sorter_start, 0); chk("rst_num_values", sorter_num_values, 0);
      chk("rst_we", {ram_we_a, ram_we_b}, 0); chk("rst_out_data", out_data, 0);
      rst = 0;
      exp_q.delete();
      return;
    end
    guard = 0;
    while (done_cnt == 0 && guard < 5000) begin tick(); guard++; end
    tick(); tick();
    chk("job_done_count", done_cnt, 1);
    chk("out_count", got_cnt, n);
    chk("busy_clear", job_busy, 0);
    chk("sorter_starts", start_cnt - st0, exp_starts);
    if (poke) chk("num_values_kept", sorter_num_values, n);
    stall_pct = 0;
  endtask

  typedef struct {
    int n;
    int stall;
    bit exp_err;
    int exp_starts;
  } vec_t;

  initial begin
    vec_t vecs[$];
    vecs.push_back('{32, 0, 0, 1});
    vecs.push_back('{20, 40, 0, 1});
    vecs.push_back('{0, 0, 1, 0});
    vecs.push_back('{1025, 0, 1, 0});
    vecs.push_back('{2, 50, 0, 1});
    vecs.push_back('{3, 0, 0, 1});
    vecs.push_back('{64, 20, 0, 1});
    vecs.push_back('{1, 30, 0, 0});

    rst = 1; job_start = 0; job_num_values = '0; in_valid = 0; in_data = '0;
    got_cnt = 0; done_cnt = 0; exp_n = 0;
    repeat (2) tick();
    chk("reset_busy", job_busy, 0);
    chk("reset_done", job_done, 0);
    chk("reset_error", job_error, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sorter_start", sorter_start, 0);
    chk("reset_num_values", sorter_num_values, 0);
    chk("reset_we", {ram_we_a, ram_we_b}, 0);
    rst = 0;
    tick();

    foreach (vecs[v]) run_job(vecs[v].n, vecs[v].stall, vecs[v].exp_err, vecs[v].exp_starts, 0, 0, 0);

    run_job(1, 0, 0, 0, 1, 0, 0);    // single 0xDEAD item bypasses the sorter
    run_job(16, 0, 0, 1, 0, 0, 1);   // reset while the sorter is running
    run_job(8, 25, 0, 1, 0, 0, 0);   // job after the reset completes normally
    run_job(12, 0, 0, 1, 0, 1, 0);   // job_start during LOAD is ignored

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
